// File: rtl/control_par.sv
// -----------------------------------------------------------------------------
// control_par
//
// DPLL solver controller with chronological backtracking and parallel BCP.
// Walks the variables looking for an unassigned one, decides it, fetches the
// clause range for the variable just assigned, splits that range across
// NUM_BCP propagation cores, then drains the imply stack. A conflict from any
// core unwinds the trace stack until a decision can be flipped; an empty trace
// during unwinding means the formula is unsatisfiable.
//
// Ports:
//   clock, reset            system clock, synchronous active-low reset
//   start, num_vars         solve request and number of active variables
//   bcp_*                   per-core start/subrange, broadcast var/value,
//                           per-core done/conflict, reset_bcp pulse
//   *_imply                 imply stack head, empty flag, pop and flush
//   *_trace                 trace stack top, empty flag, push data, pop/push
//   *_vs                    variable state read port and write port
//   read_var_start_end,
//   var_in_vse, start/end_clause
//                           per-variable clause range table read port
//   sat, unsat, busy        sticky result flags and activity indicator
//   n_decisions,
//   n_conflicts             saturating statistics counters
// -----------------------------------------------------------------------------
module control_par #(
   parameter int MAX_VARS     = 256,
   parameter int MAX_CLAUSES  = 1024,
   parameter int NUM_BCP      = 4,
   parameter bit DEC_POLARITY = 1'b0,
   parameter int STAT_W       = 32,
   localparam int VB = (MAX_VARS > 1) ? $clog2(MAX_VARS) : 1,
   localparam int CB = (MAX_CLAUSES > 1) ? $clog2(MAX_CLAUSES) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [VB-1:0]         num_vars,
   output logic [NUM_BCP-1:0]    bcp_start,
   output logic [NUM_BCP*CB-1:0] bcp_lo,
   output logic [NUM_BCP*CB-1:0] bcp_hi,
   output logic [VB-1:0]         bcp_var,
   output logic                  bcp_val,
   input  logic [NUM_BCP-1:0]    bcp_done,
   input  logic [NUM_BCP-1:0]    bcp_conflict,
   output logic                  reset_bcp,
   input  logic                  empty_imply,
   input  logic [VB-1:0]         var_out_imply,
   input  logic                  val_out_imply,
   output logic                  pop_imply,
   output logic                  flush_imply,
   input  logic                  empty_trace,
   input  logic [VB-1:0]         var_out_trace,
   input  logic                  val_out_trace,
   input  logic                  type_out_trace,
   output logic                  pop_trace,
   output logic                  push_trace,
   output logic [VB-1:0]         var_in_trace,
   output logic                  val_in_trace,
   output logic                  type_in_trace,
   output logic                  read_vs,
   output logic [VB-1:0]         var_rd_vs,
   input  logic                  unassigned_vs,
   output logic                  write_vs,
   output logic [VB-1:0]         var_in_vs,
   output logic                  val_in_vs,
   output logic                  unassign_in_vs,
   output logic                  read_var_start_end,
   output logic [VB-1:0]         var_in_vse,
   input  logic [CB-1:0]         start_clause,
   input  logic [CB-1:0]         end_clause,
   output logic                  sat,
   output logic                  unsat,
   output logic                  busy,
   output logic [STAT_W-1:0]     n_decisions,
   output logic [STAT_W-1:0]     n_conflicts
);

   // Wide enough that start + i*chunk and lo + chunk - 1 never wrap.
   localparam int LOG_B = (NUM_BCP > 1) ? $clog2(NUM_BCP) : 0;
   localparam int WW    = CB + LOG_B + 2;

   typedef enum logic [3:0] {
      S_IDLE,
      S_SCAN,
      S_SCHK,
      S_VSE_RD,
      S_SPLIT,
      S_WAIT,
      S_IMPLY,
      S_BACK,
      S_FLIP,
      S_SAT,
      S_UNSAT
   } state_t;

   state_t                  state_q, state_d;
   logic [VB-1:0]           p_q, p_d;
   logic [VB-1:0]           cur_var_q, cur_var_d;
   logic                    cur_val_q, cur_val_d;
   logic [NUM_BCP-1:0]      active_q, active_d;
   logic [NUM_BCP-1:0]      done_q, done_d;
   logic                    conf_q, conf_d;
   logic [NUM_BCP*CB-1:0]   lo_q, lo_d;
   logic [NUM_BCP*CB-1:0]   hi_q, hi_d;
   logic                    sat_q, sat_d;
   logic                    unsat_q, unsat_d;
   logic [STAT_W-1:0]       n_dec_q, n_dec_d;
   logic [STAT_W-1:0]       n_conf_q, n_conf_d;

   logic [NUM_BCP*CB-1:0]   split_lo;
   logic [NUM_BCP*CB-1:0]   split_hi;
   logic [NUM_BCP-1:0]      split_act;
   logic                    range_empty;
   logic [WW-1:0]           start_w;
   logic [WW-1:0]           end_w;
   logic [WW-1:0]           len_w;
   logic [WW-1:0]           chunk_w;
   logic [WW-1:0]           lo_w;
   logic [WW-1:0]           last_w;

   logic [NUM_BCP-1:0]      done_acc;
   logic                    conf_acc;

   // Range splitter: divides the clause range returned by the start/end table
   // into NUM_BCP contiguous chunks of ceil(len/NUM_BCP) clauses. Trailing cores
   // whose chunk starts past the end stay idle and report a zero subrange.
   always_comb begin
      split_lo    = '0;
      split_hi    = '0;
      split_act   = '0;
      lo_w        = '0;
      last_w      = '0;
      range_empty = (end_clause < start_clause);
      start_w     = WW'(start_clause);
      end_w       = WW'(end_clause);
      len_w       = end_w - start_w + WW'(1);
      chunk_w     = (len_w + WW'(NUM_BCP - 1)) >> LOG_B;
      for (int i = 0; i < NUM_BCP; i++) begin
         lo_w   = start_w + WW'(i) * chunk_w;
         last_w = lo_w + chunk_w - WW'(1);
         if (lo_w <= end_w) begin
            split_act[i]          = 1'b1;
            split_lo[i*CB +: CB]  = start_clause + CB'(i) * chunk_w[CB-1:0];
            split_hi[i*CB +: CB]  = (last_w > end_w) ? end_clause : last_w[CB-1:0];
         end
      end
   end

   // State register plus all controller bookkeeping. Reset is synchronous and
   // active low, and clears every register that feeds an output.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         p_q       <= '0;
         cur_var_q <= '0;
         cur_val_q <= 1'b0;
         active_q  <= '0;
         done_q    <= '0;
         conf_q    <= 1'b0;
         lo_q      <= '0;
         hi_q      <= '0;
         sat_q     <= 1'b0;
         unsat_q   <= 1'b0;
         n_dec_q   <= '0;
         n_conf_q  <= '0;
      end else begin
         state_q   <= state_d;
         p_q       <= p_d;
         cur_var_q <= cur_var_d;
         cur_val_q <= cur_val_d;
         active_q  <= active_d;
         done_q    <= done_d;
         conf_q    <= conf_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
         sat_q     <= sat_d;
         unsat_q   <= unsat_d;
         n_dec_q   <= n_dec_d;
         n_conf_q  <= n_conf_d;
      end
   end

   // Next-state and output decode. Every strobe defaults low; while reset is
   // asserted the decode is skipped so no pulse escapes in the reset cycle.
   always_comb begin
      state_d            = state_q;
      p_d                = p_q;
      cur_var_d          = cur_var_q;
      cur_val_d          = cur_val_q;
      active_d           = active_q;
      done_d             = done_q;
      conf_d             = conf_q;
      lo_d               = lo_q;
      hi_d               = hi_q;
      sat_d              = sat_q;
      unsat_d            = unsat_q;
      n_dec_d            = n_dec_q;
      n_conf_d           = n_conf_q;

      bcp_start          = '0;
      bcp_lo             = lo_q;
      bcp_hi             = hi_q;
      reset_bcp          = 1'b0;
      pop_imply          = 1'b0;
      flush_imply        = 1'b0;
      pop_trace          = 1'b0;
      push_trace         = 1'b0;
      var_in_trace       = '0;
      val_in_trace       = 1'b0;
      type_in_trace      = 1'b0;
      read_vs            = 1'b0;
      var_rd_vs          = '0;
      write_vs           = 1'b0;
      var_in_vs          = '0;
      val_in_vs          = 1'b0;
      unassign_in_vs     = 1'b0;
      read_var_start_end = 1'b0;
      var_in_vse         = '0;
      busy               = 1'b0;

      // Done pulses from cores that were never started are masked out.
      done_acc = done_q | (bcp_done & active_q);
      conf_acc = conf_q | (|(bcp_conflict & bcp_done & active_q));

      if (reset) begin
         busy = !(state_q inside {S_IDLE, S_SAT, S_UNSAT});
         case (state_q)
            S_IDLE, S_SAT, S_UNSAT: begin
               if (start) begin
                  sat_d    = 1'b0;
                  unsat_d  = 1'b0;
                  n_dec_d  = '0;
                  n_conf_d = '0;
                  p_d      = '0;
                  state_d  = S_SCAN;
               end
            end

            S_SCAN: begin
               if (p_q == num_vars) begin
                  sat_d   = 1'b1;
                  state_d = S_SAT;
               end else begin
                  read_vs   = 1'b1;
                  var_rd_vs = p_q;
                  state_d   = S_SCHK;
               end
            end

            S_SCHK: begin
               if (unassigned_vs) begin
                  write_vs      = 1'b1;
                  var_in_vs     = p_q;
                  val_in_vs     = DEC_POLARITY;
                  push_trace    = 1'b1;
                  var_in_trace  = p_q;
                  val_in_trace  = DEC_POLARITY;
                  type_in_trace = 1'b1;
                  cur_var_d     = p_q;
                  cur_val_d     = DEC_POLARITY;
                  if (!(&n_dec_q)) begin
                     n_dec_d = n_dec_q + STAT_W'(1);
                  end
                  state_d = S_VSE_RD;
               end else begin
                  p_d     = p_q + VB'(1);
                  state_d = S_SCAN;
               end
            end

            S_VSE_RD: begin
               read_var_start_end = 1'b1;
               var_in_vse         = cur_var_q;
               state_d            = S_SPLIT;
            end

            S_SPLIT: begin
               if (range_empty) begin
                  state_d = S_IMPLY;
               end else begin
                  bcp_start = split_act;
                  bcp_lo    = split_lo;
                  bcp_hi    = split_hi;
                  lo_d      = split_lo;
                  hi_d      = split_hi;
                  active_d  = split_act;
                  done_d    = '0;
                  conf_d    = 1'b0;
                  state_d   = S_WAIT;
               end
            end

            S_WAIT: begin
               done_d = done_acc;
               conf_d = conf_acc;
               if (done_acc == active_q) begin
                  if (conf_acc) begin
                     reset_bcp   = 1'b1;
                     flush_imply = 1'b1;
                     if (!(&n_conf_q)) begin
                        n_conf_d = n_conf_q + STAT_W'(1);
                     end
                     state_d = S_BACK;
                  end else begin
                     state_d = S_IMPLY;
                  end
               end
            end

            S_IMPLY: begin
               if (empty_imply) begin
                  p_d     = '0;
                  state_d = S_SCAN;
               end else begin
                  pop_imply     = 1'b1;
                  write_vs      = 1'b1;
                  var_in_vs     = var_out_imply;
                  val_in_vs     = val_out_imply;
                  push_trace    = 1'b1;
                  var_in_trace  = var_out_imply;
                  val_in_trace  = val_out_imply;
                  type_in_trace = 1'b0;
                  cur_var_d     = var_out_imply;
                  cur_val_d     = val_out_imply;
                  state_d       = S_VSE_RD;
               end
            end

            // Forced entries are undone one per cycle; the first decision found
            // is popped and its opposite value is pushed from FLIP next cycle,
            // so pop and push never coincide.
            S_BACK: begin
               if (empty_trace) begin
                  unsat_d = 1'b1;
                  state_d = S_UNSAT;
               end else if (!type_out_trace) begin
                  pop_trace      = 1'b1;
                  write_vs       = 1'b1;
                  var_in_vs      = var_out_trace;
                  unassign_in_vs = 1'b1;
               end else begin
                  pop_trace = 1'b1;
                  cur_var_d = var_out_trace;
                  cur_val_d = ~val_out_trace;
                  state_d   = S_FLIP;
               end
            end

            S_FLIP: begin
               write_vs      = 1'b1;
               var_in_vs     = cur_var_q;
               val_in_vs     = cur_val_q;
               push_trace    = 1'b1;
               var_in_trace  = cur_var_q;
               val_in_trace  = cur_val_q;
               type_in_trace = 1'b0;
               state_d       = S_VSE_RD;
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign bcp_var     = cur_var_q;
   assign bcp_val     = cur_val_q;
   assign sat         = sat_q;
   assign unsat       = unsat_q;
   assign n_decisions = n_dec_q;
   assign n_conflicts = n_conf_q;

endmodule

// File: doc/control_par.md
Name: control_par

Overview:
- Parametrised DPLL solver controller with chronological backtracking.
- Sequences decide → assign → clause-range lookup → parallel BCP → implication drain → backtrack.
- Owns the trace stack, imply stack, var state and var start/end table handshakes.
- Successor to the single-BCP controller: splits each variable's clause range across NUM_BCP cores, adds a variable scan for decisions, imply flush and statistics counters.

Parameters:
- MAX_VARS, 256, variable capacity; VB = clog2(MAX_VARS).
- MAX_CLAUSES, 1024, clause capacity; CB = clog2(MAX_CLAUSES).
- NUM_BCP, 4, parallel BCP cores; power of two, ≥1.
- DEC_POLARITY, 0, value given to fresh decisions.
- STAT_W, 32, statistics counter width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin solve (accepted in IDLE/SAT/UNSAT)
- num_vars  in  VB  active variables 0..num_vars-1
- bcp_start  out  NUM_BCP  per-core one-cycle start pulse
- bcp_lo, bcp_hi  out  NUM_BCP*CB each  per-core inclusive clause subrange
- bcp_var  out  VB  variable just assigned (broadcast)
- bcp_val  out  1  its value (broadcast)
- bcp_done  in  NUM_BCP  per-core one-cycle completion pulse
- bcp_conflict  in  NUM_BCP  valid with bcp_done
- reset_bcp  out  1  one-cycle pulse after a conflict
- empty_imply  in  1  imply stack empty
- var_out_imply  in  VB  head variable (valid when !empty)
- val_out_imply  in  1  head value (valid when !empty)
- pop_imply  out  1  pop imply head
- flush_imply  out  1  clear imply stack
- empty_trace  in  1  trace stack empty
- var_out_trace  in  VB  trace top variable
- val_out_trace  in  1  trace top value
- type_out_trace  in  1  trace top type (1 = flippable decision, 0 = forced)
- pop_trace, push_trace  out  1 each  trace stack pop / push
- var_in_trace, val_in_trace, type_in_trace  out  VB/1/1  trace push data
- read_vs  out  1  var state read strobe
- var_rd_vs  out  VB  var state read address
- unassigned_vs  in  1  read result, valid one cycle after read_vs
- write_vs  out  1  var state write strobe
- var_in_vs, val_in_vs, unassign_in_vs  out  VB/1/1  var state write data
- read_var_start_end  out  1  VSE read strobe
- var_in_vse  out  VB  VSE read address
- start_clause, end_clause  in  CB each  valid one cycle after read
- sat, unsat  out  1 each  sticky result
- busy  out  1  high outside IDLE/SAT/UNSAT
- n_decisions, n_conflicts  out  STAT_W each  saturating counters

Behaviour:
- Reset (reset=0 at posedge): state IDLE. All strobes, pulses, sat, unsat, busy and counters = 0; data outputs = 0. Takes effect from any state; no pulses issued in the reset cycle.
- Strobes and pulses are single-cycle unless stated.
- IDLE/SAT/UNSAT on start: clear sat, unsat and counters → SCAN (scan pointer p = 0).
- SCAN:
  - If p == num_vars → SAT.
  - Otherwise read_vs with var_rd_vs = p → SCHK.
- SCHK:
  - If unassigned_vs: write_vs(p, DEC_POLARITY, unassign=0), push_trace(p, DEC_POLARITY, type=1), n_decisions++ → VSE_RD.
  - Otherwise p++ → SCAN.
- VSE_RD: read_var_start_end with the current variable → SPLIT.
- SPLIT:
  - If end_clause < start_clause: range is empty → IMPLY.
  - Otherwise len = end − start + 1 and chunk = ceil(len/NUM_BCP), computed by shift.
  - Core i gets lo = start + i·chunk and hi = min(lo + chunk − 1, end).
  - A core is active iff lo ≤ end.
  - Assert bcp_start on active cores, drive bcp_var/bcp_val, clear the done mask → WAIT.
- WAIT:
  - Accumulate bcp_done and OR in bcp_conflict.
  - When the mask equals the active set: on any conflict → pulse reset_bcp and flush_imply, n_conflicts++ → BACK. Otherwise → IMPLY.
  - Done pulses from inactive cores are ignored.
- IMPLY:
  - If empty_imply → SCAN (p = 0).
  - Otherwise in the same cycle: pop_imply, write_vs(head, val), push_trace(head, val, type=0) → VSE_RD.
- BACK:
  - If empty_trace → UNSAT.
  - If type_out_trace = 0: pop_trace and write_vs(var, unassign=1); stay in BACK. The trace output updates the next cycle.
  - If type_out_trace = 1: pop_trace, latch the variable and its inverted value → FLIP.
- FLIP: write_vs(var, ~val), push_trace(var, ~val, type=0) → VSE_RD.
- pop_trace and push_trace are never asserted in the same cycle.
- SAT/UNSAT: the flag is held until start or reset; busy = 0.
- Counters saturate at all-ones.

Test Plan:
- NUM_BCP=4, start=5, end=14 → cores 0..2 receive 5–7, 8–10, 11–13; core 3 receives 14–14; all four bcp_start asserted in one cycle.
- start=5, end=6 with NUM_BCP=4 → cores 0,1 active (5–5, 6–6); cores 2,3 never started; WAIT exits after 2 dones arrive on different cycles.
- num_vars=2, no conflicts, imply always empty → decisions on var 0 then var 1, n_decisions=2, sat=1, unsat=0.
- Conflict on the first decision of var 0 → reset_bcp and flush_imply pulse; trace popped; var 0 rewritten to 1 with type 0; push_trace one cycle after pop_trace.
- Conflict again after the flip, trace holding only forced entries → BACK pops each entry, then empty_trace → unsat=1, n_conflicts=2.
- reset=0 asserted while in WAIT → next cycle IDLE, all outputs 0; a later start restarts cleanly.
